// File: rtl/cyc_pkg.sv
// Shared types and sizes for the memory-cycle arbiter.
//  - cyc_state_e : bus-cycle sequencer states
//  - cyc_owner_e : which requester currently owns the local memory bus
//  - WCNT_W / TCNT_W : widths of the wait-state and timeout counters
//  - eff_wait()  : wait-state budget after the SHORT trim (never below zero)
package cyc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    TERM = 3'd3,
    RCV  = 3'd4
  } cyc_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2,
    RFSH = 2'd3
  } cyc_owner_e;

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;

  // SHORT removes one wait state, but a zero budget stays zero.
  function automatic logic [WCNT_W-1:0] eff_wait(input logic [WCNT_W-1:0] base,
                                                 input logic             short_i);
    logic [WCNT_W-1:0] res;
    if (short_i && (base != WCNT_W'(0))) begin
      res = base - WCNT_W'(1);
    end else begin
      res = base;
    end
    return res;
  endfunction

endpackage

// File: rtl/cyc_wait_counter.sv
// Wait-state and timeout counting for one bus cycle.
// Ports:
//  clk       in  clock
//  rst       in  synchronous active-high reset
//  load      in  ADDR clock: load wait budget, clear timeout count
//  run       in  WAIT clock: count
//  slow      in  memory not ready; freezes the wait count
//  load_val  in  wait budget to load
//  wait_done out this WAIT clock is the last one (budget used up, memory ready)
//  tmo_hit   out this WAIT clock reaches the timeout limit
module cyc_wait_counter
  import cyc_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic              slow,
  input  logic [WCNT_W-1:0] load_val,
  output logic              wait_done,
  output logic              tmo_hit
);

  localparam int unsigned       TMO_M1     = TMO - 1;
  localparam logic [TCNT_W-1:0] TMO_LAST_C = TMO_M1[TCNT_W-1:0];
  localparam logic [TCNT_W-1:0] TCNT_MAX_C = {TCNT_W{1'b1}};

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  // Next counter values: load in ADDR, count down/up in WAIT, otherwise hold.
  always_comb begin
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    if (load) begin
      wcnt_d = load_val;
      tcnt_d = TCNT_W'(0);
    end else if (run) begin
      if (!slow && (wcnt_q != WCNT_W'(0))) begin
        wcnt_d = wcnt_q - WCNT_W'(1);
      end else begin
        wcnt_d = wcnt_q;
      end
      if (tcnt_q != TCNT_MAX_C) begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end else begin
        tcnt_d = tcnt_q;
      end
    end else begin
      wcnt_d = wcnt_q;
      tcnt_d = tcnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= WCNT_W'(0);
      tcnt_q <= TCNT_W'(0);
    end else begin
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  // The count holds the WAIT clocks still owed including the current one,
  // so the cycle ends on the clock where it is 1 and memory is ready.
  assign wait_done = run && !slow && (wcnt_q <= WCNT_W'(1));
  // tcnt_q is the number of WAIT clocks already completed.
  assign tmo_hit   = run && (tcnt_q == TMO_LAST_C);

endmodule

// File: rtl/cyc_mem_arbiter.sv
// Memory-cycle arbiter/sequencer: shares the local memory bus between CPU,
// DMA and refresh, runs ADDR/WAIT/TERM/RCV, and aborts with BERR on timeout.
// Ports:
//  OSC in clock            MR in sync reset (active high)
//  CREQ/CWRITE  CPU request and write qualifier
//  DREQ/DWRITE  DMA request and write qualifier
//  RFREQ        refresh request
//  SLOW         memory not ready (stalls WAIT)
//  SHORT        trims one wait state, captured with the grant
//  CGNT/DGNT/RFGNT  one-hot grants, ADDR..TERM
//  MREQ_n  bus strobe        WRITE  latched write qualifier
//  TERM_n  end-of-cycle      BERR   timeout abort, with TERM_n
//  BUSY    not idle
module cyc_mem_arbiter
  import cyc_pkg::*;
#(
  parameter int unsigned WAIT_CPU  = 3,
  parameter int unsigned WAIT_DMA  = 4,
  parameter int unsigned DMA_BURST = 4,
  parameter int unsigned TMO       = 255
) (
  input  logic OSC,
  input  logic MR,
  input  logic CREQ,
  input  logic CWRITE,
  input  logic DREQ,
  input  logic DWRITE,
  input  logic RFREQ,
  input  logic SLOW,
  input  logic SHORT,
  output logic CGNT,
  output logic DGNT,
  output logic RFGNT,
  output logic MREQ_n,
  output logic WRITE,
  output logic TERM_n,
  output logic BERR,
  output logic BUSY
);

  localparam logic [WCNT_W-1:0] WAIT_CPU_C = WAIT_CPU[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] WAIT_DMA_C = WAIT_DMA[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] BURST_C    = DMA_BURST[WCNT_W-1:0];

  cyc_state_e        state_q, state_d;
  cyc_owner_e        owner_q, owner_d;
  cyc_owner_e        arb_owner;
  logic [WCNT_W-1:0] burst_q, burst_d;
  logic              short_q, short_d;
  logic              write_q, write_d;
  logic              cgnt_q, cgnt_d, dgnt_q, dgnt_d, rfgnt_q, rfgnt_d;
  logic              mreq_n_q, mreq_n_d, term_n_q, term_n_d;
  logic              berr_q, berr_d, busy_q, busy_d;
  logic [WCNT_W-1:0] base_sel, eff_wait_v;
  logic              wait_done, tmo_hit;

  cyc_wait_counter #(.TMO(TMO)) u_wait (
    .clk       (OSC),
    .rst       (MR),
    .load      (state_q == ADDR),
    .run       (state_q == WAIT),
    .slow      (SLOW),
    .load_val  (eff_wait_v),
    .wait_done (wait_done),
    .tmo_hit   (tmo_hit)
  );

  // Fixed priority RFREQ > DREQ > CREQ, except a CPU kept waiting by a full DMA burst wins.
  always_comb begin
    arb_owner = NONE;
    if (CREQ && (burst_q == BURST_C)) begin
      arb_owner = CPU;
    end else if (RFREQ) begin
      arb_owner = RFSH;
    end else if (DREQ) begin
      arb_owner = DMA;
    end else if (CREQ) begin
      arb_owner = CPU;
    end else begin
      arb_owner = NONE;
    end
  end

  // Wait budget for the owner; refresh uses the DMA timing.
  always_comb begin
    if (owner_q == CPU) begin
      base_sel = WAIT_CPU_C;
    end else begin
      base_sel = WAIT_DMA_C;
    end
    eff_wait_v = eff_wait(base_sel, short_q);
  end

  // Sequencer next state plus the output values for the next clock.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    short_d = short_q;
    write_d = write_q;
    berr_d  = 1'b0;
    case (state_q)
      IDLE, RCV: begin
        if (arb_owner != NONE) begin
          state_d = ADDR;
          owner_d = arb_owner;
          short_d = SHORT;
          case (arb_owner)
            CPU: begin
              write_d = CWRITE;
              burst_d = WCNT_W'(0);
            end
            DMA: begin
              write_d = DWRITE;
              if (burst_q < BURST_C) begin
                burst_d = burst_q + WCNT_W'(1);
              end else begin
                burst_d = burst_q;
              end
            end
            default: begin
              write_d = 1'b0;
              burst_d = WCNT_W'(0);
            end
          endcase
        end else begin
          state_d = IDLE;
          owner_d = NONE;
          write_d = 1'b0;
        end
      end
      ADDR: begin
        if (eff_wait_v == WCNT_W'(0)) begin
          state_d = TERM;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Timeout takes precedence so an abort is never reported as a clean end.
        if (tmo_hit) begin
          state_d = TERM;
          berr_d  = 1'b1;
        end else if (wait_done) begin
          state_d = TERM;
        end else begin
          state_d = WAIT;
        end
      end
      TERM: begin
        state_d = RCV;
        owner_d = NONE;
        write_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
        write_d = 1'b0;
      end
    endcase

    cgnt_d   = (owner_d == CPU);
    dgnt_d   = (owner_d == DMA);
    rfgnt_d  = (owner_d == RFSH);
    mreq_n_d = !((state_d == ADDR) || (state_d == WAIT) || (state_d == TERM));
    term_n_d = (state_d != TERM);
    busy_d   = (state_d != IDLE);
  end

  // State and registered outputs; MR aborts any cycle without a TERM_n pulse.
  always_ff @(posedge OSC) begin
    if (MR) begin
      state_q  <= IDLE;
      owner_q  <= NONE;
      burst_q  <= WCNT_W'(0);
      short_q  <= 1'b0;
      write_q  <= 1'b0;
      cgnt_q   <= 1'b0;
      dgnt_q   <= 1'b0;
      rfgnt_q  <= 1'b0;
      mreq_n_q <= 1'b1;
      term_n_q <= 1'b1;
      berr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      short_q  <= short_d;
      write_q  <= write_d;
      cgnt_q   <= cgnt_d;
      dgnt_q   <= dgnt_d;
      rfgnt_q  <= rfgnt_d;
      mreq_n_q <= mreq_n_d;
      term_n_q <= term_n_d;
      berr_q   <= berr_d;
      busy_q   <= busy_d;
    end
  end

  assign CGNT   = cgnt_q;
  assign DGNT   = dgnt_q;
  assign RFGNT  = rfgnt_q;
  assign MREQ_n = mreq_n_q;
  assign WRITE  = write_q;
  assign TERM_n = term_n_q;
  assign BERR   = berr_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_cyc_mem_arbiter.sv
// Scoreboard bench for cyc_mem_arbiter: a transaction-level model predicts
// every bus cycle (owner, write, first/last clock, BERR) when it is granted;
// a negedge monitor checks what the DUT actually presents.
module tb_cyc_mem_arbiter;

  localparam int WAIT_CPU_P = 3;
  localparam int WAIT_DMA_P = 4;
  localparam int BURST_P    = 4;
  localparam int TMO_P      = 255;
  localparam int DEPTH      = 4096;

  logic OSC = 1'b0, MR = 1'b1;
  logic CREQ = 1'b0, CWRITE = 1'b0, DREQ = 1'b0, DWRITE = 1'b0;
  logic RFREQ = 1'b0, SLOW = 1'b0, SHORT = 1'b0;
  logic CGNT, DGNT, RFGNT, MREQ_n, WRITE, TERM_n, BERR, BUSY;

  cyc_mem_arbiter #(
    .WAIT_CPU(WAIT_CPU_P), .WAIT_DMA(WAIT_DMA_P), .DMA_BURST(BURST_P), .TMO(TMO_P)
  ) dut (
    .OSC(OSC), .MR(MR), .CREQ(CREQ), .CWRITE(CWRITE), .DREQ(DREQ), .DWRITE(DWRITE),
    .RFREQ(RFREQ), .SLOW(SLOW), .SHORT(SHORT), .CGNT(CGNT), .DGNT(DGNT), .RFGNT(RFGNT),
    .MREQ_n(MREQ_n), .WRITE(WRITE), .TERM_n(TERM_n), .BERR(BERR), .BUSY(BUSY)
  );

  always #5 OSC = ~OSC;

  // Clock index: cycle c is the interval following the c-th rising edge.
  int cyc = 0;
  always @(posedge OSC) cyc <= cyc + 1;

  typedef struct {
    int owner;   // 0 cpu, 1 dma, 2 refresh
    bit wr;
    int start;   // first clock with grant (ADDR)
    int term;    // clock with TERM_n low
    bit berr;
  } txn_t;

  txn_t exp_q[$];
  bit   slow_arr[DEPTH];
  bit   exp_busy[DEPTH];
  int   pending[3];
  int   cur_term  = -10;
  int   cur_owner = -1;
  int   burst     = 0;
  int   k         = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  bit   mon_en    = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cgnt"},   int'(CGNT),   0);
    check({tag, "_dgnt"},   int'(DGNT),   0);
    check({tag, "_rfgnt"},  int'(RFGNT),  0);
    check({tag, "_mreq_n"}, int'(MREQ_n), 1);
    check({tag, "_write"},  int'(WRITE),  0);
    check({tag, "_term_n"}, int'(TERM_n), 1);
    check({tag, "_berr"},   int'(BERR),   0);
    check({tag, "_busy"},   int'(BUSY),   0);
  endtask

  // ADDR at clock g; each WAIT clock with SLOW low pays one wait state;
  // after TMO_P WAIT clocks the cycle is aborted (abort wins a tie).
  function automatic void calc_term(input int g, input int eff, output int term, output bit berr);
    int done;
    int w;
    done = 0;
    w    = 0;
    if (eff == 0) begin
      term = g + 1;
      berr = 1'b0;
    end else begin
      while ((w < TMO_P) && (done < eff)) begin
        w++;
        if (!slow_arr[g + w]) done++;
      end
      berr = (w == TMO_P);
      term = g + w + 1;
    end
  endfunction

  // One clock of requester behaviour plus the reference arbitration decision.
  task automatic step(input int prob);
    int win, base, eff, t;
    bit b, wr;
    @(posedge OSC);
    #1;
    k = cyc;
    if ((cur_owner >= 0) && (k == cur_term + 1)) begin
      pending[cur_owner]--;
      cur_owner = -1;
    end
    for (int r = 0; r < 3; r++)
      if ((pending[r] < 3) && ($urandom_range(0, 99) < prob)) pending[r]++;
    CREQ   = (pending[0] > 0);
    DREQ   = (pending[1] > 0);
    RFREQ  = (pending[2] > 0);
    CWRITE = ($urandom_range(0, 1) == 1);
    DWRITE = ($urandom_range(0, 1) == 1);
    SHORT  = ($urandom_range(0, 3) == 0);
    SLOW   = slow_arr[k];
    if ((k > cur_term) && (CREQ || DREQ || RFREQ)) begin
      if (CREQ && (burst == BURST_P)) win = 0;
      else if (RFREQ)                 win = 2;
      else if (DREQ)                  win = 1;
      else                            win = 0;
      if (win == 1) burst = (burst < BURST_P) ? burst + 1 : burst;
      else          burst = 0;
      base = (win == 0) ? WAIT_CPU_P : WAIT_DMA_P;
      eff  = (SHORT && (base > 0)) ? base - 1 : base;
      wr   = (win == 0) ? CWRITE : ((win == 1) ? DWRITE : 1'b0);
      calc_term(k + 1, eff, t, b);
      exp_q.push_back('{owner: win, wr: wr, start: k + 1, term: t, berr: b});
      for (int j = k + 1; j <= t + 1; j++) exp_busy[j] = 1'b1;
      cur_term  = t;
      cur_owner = win;
    end
  endtask

  // Monitor: per-clock bus sanity plus scoreboard pop at every TERM_n.
  bit   prev_g = 1'b0;
  bit   any_g;
  int   o_start = 0;
  bit   o_wr    = 1'b0;
  int   own_now;
  txn_t e;
  always @(negedge OSC) begin
    if (mon_en) begin
      any_g = CGNT || DGNT || RFGNT;
      check("grant_onehot", int'((int'(CGNT) + int'(DGNT) + int'(RFGNT)) <= 1), 1);
      check("mreq_n_vs_grant", int'(MREQ_n), int'(!any_g));
      check("busy", int'(BUSY), int'(exp_busy[cyc]));
      if (TERM_n) check("berr_outside_term", int'(BERR), 0);
      if (any_g && !prev_g) begin
        o_start = cyc;
        o_wr    = WRITE;
      end
      if (!TERM_n) begin
        own_now = CGNT ? 0 : (DGNT ? 1 : (RFGNT ? 2 : -1));
        if (exp_q.size() == 0) begin
          check("unexpected_term", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("owner",      own_now,      e.owner);
          check("start_cyc",  o_start,      e.start);
          check("term_cyc",   cyc,          e.term);
          check("write",      int'(o_wr),   int'(e.wr));
          check("write_held", int'(WRITE),  int'(e.wr));
          check("berr",       int'(BERR),   int'(e.berr));
        end
      end
      prev_g = any_g;
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      slow_arr[i] = ($urandom_range(0, 4) == 0);
      exp_busy[i] = 1'b0;
    end
    // Memory stuck not-ready long enough to force timeout aborts.
    for (int i = 500; i < 900; i++) slow_arr[i] = 1'b1;
    for (int r = 0; r < 3; r++) pending[r] = 0;

    repeat (3) @(posedge OSC);
    @(negedge OSC);
    check_reset("por");
    @(posedge OSC);
    #1;
    MR = 1'b0;
    mon_en = 1'b1;

    // Heavy load (burst limit, priority, back-to-back), then sparse load.
    repeat (1200) step(35);
    repeat (600) step(6);

    guard = 0;
    while (((pending[0] + pending[1] + pending[2]) > 0 || (k <= cur_term + 1)) && (guard < 800)) begin
      step(0);
      guard++;
    end
    if (guard >= 800) check("drain_timeout", 1, 0);
    @(negedge OSC);
    check("queue_empty", exp_q.size(), 0);

    // Master reset in the middle of a WAIT state.
    mon_en = 1'b0;
    @(posedge OSC); #1;
    CREQ = 1'b1; CWRITE = 1'b1; SLOW = 1'b1; SHORT = 1'b0;
    @(posedge OSC); #1;
    CREQ = 1'b0;
    @(posedge OSC); #1;
    @(negedge OSC);
    check("mr_pre_busy",   int'(BUSY),   1);
    check("mr_pre_cgnt",   int'(CGNT),   1);
    check("mr_pre_mreq_n", int'(MREQ_n), 0);
    check("mr_pre_term_n", int'(TERM_n), 1);
    MR = 1'b1;
    @(posedge OSC); #1;
    MR = 1'b0;
    SLOW = 1'b0;
    @(negedge OSC);
    check_reset("mr_wait");
    repeat (4) begin
      @(negedge OSC);
      check("mr_no_term", int'(TERM_n), 1);
      check("mr_idle",    int'(BUSY),   0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
